// File: rtl/ray_pkg.sv
// ray_pkg: shared types and constants for the camera-ray generator.
//   fip32_t : one Q16.16 signed fixed-point scalar
//   vec3_t  : three fixed-point components (x, y, z)
//   ray_t   : [0] = origin, [1] = direction
//   FIP_ONE : 1.0 in Q16.16
//   state_t : generator FSM states
package ray_pkg;

  typedef logic signed [31:0] fip32_t;
  typedef fip32_t [0:2] vec3_t;
  typedef vec3_t [0:1] ray_t;

  localparam fip32_t FIP_ONE = 32'sh0001_0000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/fip_32_adder.sv
// fip_32_adder: 32-bit two's-complement Q16.16 adder with wrap-around.
//   a, b     : signed addends
//   sum      : wrapped 32-bit result
//   overflow : signed overflow of this add
module fip_32_adder (
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  output logic signed [31:0] sum,
  output logic               overflow
);

  assign sum = a + b;

  // Overflow only when both operands share a sign and the result flips it.
  assign overflow = (a[31] == b[31]) && (sum[31] != a[31]);

endmodule

// File: rtl/ray_gen_vec3_add.sv
// ray_gen_vec3_add: component-wise add of two Q16.16 3-vectors.
//   a, b     : input vectors
//   sum      : wrapped component sums
//   overflow : OR of the per-component overflow flags
module ray_gen_vec3_add
  import ray_pkg::*;
(
  input  logic signed [0:2][31:0] a,
  input  logic signed [0:2][31:0] b,
  output logic signed [0:2][31:0] sum,
  output logic                    overflow
);

  logic [2:0] comp_ovf;

  for (genvar c = 0; c < 3; c++) begin : g_comp
    fip_32_adder u_add (
      .a        (a[c]),
      .b        (b[c]),
      .sum      (sum[c]),
      .overflow (comp_ovf[c])
    );
  end

  assign overflow = |comp_ovf;

endmodule

// File: rtl/ray_gen.sv
// ray_gen: streaming camera-ray generator. After a start it emits one ray
// per pixel in raster order over a valid/ready handshake. Directions are
// built incrementally: +du per pixel along a row, +dv per row.
//   clk, reset            : clock, asynchronous active-high reset
//   i_start               : begin a frame (only honoured in IDLE)
//   i_eye/i_base/i_du/i_dv: camera origin, pixel (0,0) direction, steps
//   o_ray                 : [0] origin, [1] direction
//   o_valid / i_ready     : output handshake
//   o_px, o_py, o_last    : pixel coordinates, last-pixel flag
//   o_busy, o_done        : frame in progress, end-of-frame pulse
//   o_overflow            : sticky direction-add overflow for this frame
module ray_gen
  import ray_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_start,
  input  logic signed [0:2][31:0]         i_eye,
  input  logic signed [0:2][31:0]         i_base,
  input  logic signed [0:2][31:0]         i_du,
  input  logic signed [0:2][31:0]         i_dv,
  output logic signed [0:1][0:2][31:0]    o_ray,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [$clog2(WIDTH+1)-1:0]      o_px,
  output logic [$clog2(HEIGHT+1)-1:0]     o_py,
  output logic                            o_last,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_overflow
);

  localparam int PXW = $clog2(WIDTH + 1);
  localparam int PYW = $clog2(HEIGHT + 1);
  localparam logic [PXW-1:0] PX_LAST = PXW'(WIDTH - 1);
  localparam logic [PYW-1:0] PY_LAST = PYW'(HEIGHT - 1);

  state_t state;
  vec3_t  eye_q;
  vec3_t  du_q;
  vec3_t  dv_q;
  vec3_t  dir_q;
  vec3_t  row_base_q;

  vec3_t  dir_step;
  vec3_t  row_step;
  logic   du_ovf;
  logic   dv_ovf;

  // Next direction along the row, and the first direction of the next row.
  ray_gen_vec3_add u_add_du (
    .a        (dir_q),
    .b        (du_q),
    .sum      (dir_step),
    .overflow (du_ovf)
  );

  ray_gen_vec3_add u_add_dv (
    .a        (row_base_q),
    .b        (dv_q),
    .sum      (row_step),
    .overflow (dv_ovf)
  );

  assign o_ray[0] = eye_q;
  assign o_ray[1] = dir_q;

  // FSM plus pixel walk. o_last is precomputed whenever the pixel counters
  // move so it is ready in the same cycle as the ray it describes.
  // Overflow only accumulates from the add that actually gets registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      eye_q      <= '0;
      du_q       <= '0;
      dv_q       <= '0;
      dir_q      <= '0;
      row_base_q <= '0;
      o_px       <= '0;
      o_py       <= '0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_last     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            eye_q      <= i_eye;
            du_q       <= i_du;
            dv_q       <= i_dv;
            dir_q      <= i_base;
            row_base_q <= i_base;
            o_px       <= '0;
            o_py       <= '0;
            o_overflow <= 1'b0;
            o_last     <= (WIDTH == 1) && (HEIGHT == 1);
            o_valid    <= 1'b1;
            o_busy     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (i_ready) begin
            if (o_last) begin
              o_valid <= 1'b0;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
              state   <= IDLE;
            end else if (o_px != PX_LAST) begin
              dir_q      <= dir_step;
              o_px       <= o_px + 1'b1;
              o_overflow <= o_overflow | du_ovf;
              o_last     <= ((o_px + 1'b1) == PX_LAST) && (o_py == PY_LAST);
            end else begin
              row_base_q <= row_step;
              dir_q      <= row_step;
              o_px       <= '0;
              o_py       <= o_py + 1'b1;
              o_overflow <= o_overflow | dv_ovf;
              o_last     <= (WIDTH == 1) && ((o_py + 1'b1) == PY_LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_gen.sv
// tb_ray_gen: randomized bench for ray_gen. A reference model expands each
// accepted frame into its full list of expected rays (direction computed
// directly as base + x*du + y*dv) and one compare process checks the DUT
// against it on every falling edge. A second 1x1 instance covers the
// single-pixel frame.
module tb_ray_gen;
  import ray_pkg::*;

  localparam int W = 3;
  localparam int H = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Main 3x2 instance
  logic                          start, ready;
  vec3_t                         eye, base, du, dv;
  ray_t                          o_ray;
  logic                          o_valid, o_last, o_busy, o_done, o_overflow;
  logic [$clog2(W+1)-1:0]        o_px;
  logic [$clog2(H+1)-1:0]        o_py;

  // Single-pixel instance
  logic  s_start, s_ready;
  vec3_t s_eye, s_base, s_du, s_dv;
  ray_t  s_ray;
  logic  s_valid, s_last, s_busy, s_done, s_overflow;
  logic  s_px, s_py;

  ray_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .i_start(start),
    .i_eye(eye), .i_base(base), .i_du(du), .i_dv(dv),
    .o_ray(o_ray), .o_valid(o_valid), .i_ready(ready),
    .o_px(o_px), .o_py(o_py), .o_last(o_last), .o_busy(o_busy),
    .o_done(o_done), .o_overflow(o_overflow)
  );

  ray_gen #(.WIDTH(1), .HEIGHT(1)) dut_1x1 (
    .clk(clk), .reset(reset), .i_start(s_start),
    .i_eye(s_eye), .i_base(s_base), .i_du(s_du), .i_dv(s_dv),
    .o_ray(s_ray), .o_valid(s_valid), .i_ready(s_ready),
    .o_px(s_px), .o_py(s_py), .o_last(s_last), .o_busy(s_busy),
    .o_done(s_done), .o_overflow(s_overflow)
  );

  typedef struct {
    int    px;
    int    py;
    vec3_t eye;
    vec3_t dir;
    bit    last;
    bit    ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   done_pending = 1'b0;
  bit   post_ovf = 1'b0;
  int   pops = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic vec3_t mk(input int x, input int y, input int z);
    vec3_t v;
    v[0] = x * FIP_ONE;
    v[1] = y * FIP_ONE;
    v[2] = z * FIP_ONE;
    return v;
  endfunction

  // Expand a frame into its expected rays. Overflow of pixel k reflects
  // whether the add that produced that pixel's direction left 32-bit range,
  // accumulated over the frame.
  task automatic buildFrame(input vec3_t e, input vec3_t b, input vec3_t u, input vec3_t v);
    vec3_t  grid[H][W];
    vec3_t  src, stp;
    longint exact;
    bit     ovf;
    exp_t   ent;
    ovf = 1'b0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        for (int c = 0; c < 3; c++)
          grid[y][x][c] = 32'(longint'($signed(b[c])) + longint'(x) * longint'($signed(u[c]))
                                                       + longint'(y) * longint'($signed(v[c])));
        if (x > 0 || y > 0) begin
          if (x > 0) begin src = grid[y][x-1]; stp = u; end
          else       begin src = grid[y-1][0]; stp = v; end
          for (int c = 0; c < 3; c++) begin
            exact = longint'($signed(src[c])) + longint'($signed(stp[c]));
            if (exact > 64'sd2147483647 || exact < -64'sd2147483648) ovf = 1'b1;
          end
        end
        ent.px   = x;
        ent.py   = y;
        ent.eye  = e;
        ent.dir  = grid[y][x];
        ent.last = (x == W-1) && (y == H-1);
        ent.ovf  = ovf;
        exp_q.push_back(ent);
      end
    end
  endtask

  // Present a camera and pulse start for one cycle, then queue the frame.
  task automatic applyStimulus(input vec3_t e, input vec3_t b, input vec3_t u, input vec3_t v);
    @(posedge clk); #1;
    eye = e; base = b; du = u; dv = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    buildFrame(e, b, u, v);
  endtask

  // Compare process body: every falling edge outside reset.
  task automatic checkOutput();
    exp_t e;
    bit   want_valid;
    want_valid = (exp_q.size() > 0);
    check("valid", o_valid, want_valid);
    check("busy", o_busy, want_valid);
    check("done", o_done, done_pending);
    done_pending = 1'b0;
    if (want_valid) begin
      e = exp_q[0];
      check("px", o_px, e.px);
      check("py", o_py, e.py);
      check("last", o_last, e.last);
      check("overflow", o_overflow, e.ovf);
      check("origin", o_ray[0], e.eye);
      check("direction", o_ray[1], e.dir);
      if (o_valid && ready) begin
        void'(exp_q.pop_front());
        pops++;
        post_ovf = e.ovf;
        if (exp_q.size() == 0) done_pending = 1'b1;
      end
    end else begin
      check("overflow_idle", o_overflow, post_ovf);
    end
  endtask

  always @(negedge clk) if (!reset) checkOutput();

  // Drive random backpressure until the frame and its done pulse are seen.
  task automatic driveFrame(input int ready_pct, input bit junk);
    int cyc;
    cyc = 0;
    while ((exp_q.size() > 0 || done_pending) && cyc < 500) begin
      @(posedge clk); #1;
      ready = ($urandom_range(0, 99) < ready_pct);
      if (junk && cyc == 2 && exp_q.size() > 1) begin
        start = 1'b1;
        eye   = {$urandom, $urandom, $urandom};
        base  = {$urandom, $urandom, $urandom};
        du    = {$urandom, $urandom, $urandom};
        dv    = {$urandom, $urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 500) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL frame_timeout: %0d rays still pending after %0d cycles", exp_q.size(), cyc);
      exp_q.delete();
      done_pending = 1'b0;
    end
  endtask

  initial begin
    vec3_t zero, m1, ubase, ustep_u, ustep_v, vbase, vr;
    int    p0, cyc;

    reset = 1'b1; start = 1'b0; ready = 1'b0;
    eye = '0; base = '0; du = '0; dv = '0;
    s_start = 1'b0; s_ready = 1'b1;
    s_eye = '0; s_base = '0; s_du = '0; s_dv = '0;
    zero = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_last", o_last, 1'b0);
    check("rst_overflow", o_overflow, 1'b0);
    check("rst_ray", {o_ray[0], o_ray[1]} == '0, 1'b1);
    check("rst_px", o_px, 0);
    check("rst_py", o_py, 0);
    reset = 1'b0;

    // Canonical frame, no stalls; the model's expansion is pinned by hand.
    m1 = mk(-1, -1, -1);
    ustep_u = mk(1, 0, 0);
    ustep_v = mk(0, 1, 0);
    applyStimulus(zero, m1, ustep_u, ustep_v);
    check("pin_dir0", exp_q[0].dir, mk(-1, -1, -1));
    check("pin_dir1", exp_q[1].dir, mk( 0, -1, -1));
    check("pin_dir2", exp_q[2].dir, mk( 1, -1, -1));
    check("pin_dir3", exp_q[3].dir, mk(-1,  0, -1));
    check("pin_dir4", exp_q[4].dir, mk( 0,  0, -1));
    check("pin_dir5", exp_q[5].dir, mk( 1,  0, -1));
    check("pin_last", {exp_q[4].last, exp_q[5].last}, 2'b01);
    check("pin_ovf", exp_q[5].ovf, 1'b0);
    driveFrame(100, 1'b0);

    // Same frame, random stalls and an ignored mid-frame start.
    p0 = pops;
    applyStimulus(zero, m1, ustep_u, ustep_v);
    driveFrame(50, 1'b1);
    check("handshakes", pops - p0, W * H);

    // Overflow on the second pixel of the first row; sticky to frame end.
    ubase = '0;
    ubase[0] = 32'sh7FFF_0000;
    applyStimulus(zero, ubase, ustep_u, ustep_v);
    check("pin_wrap", exp_q[1].dir[0], 32'sh8000_0000);
    check("pin_wrap_ovf", {exp_q[0].ovf, exp_q[1].ovf, exp_q[5].ovf}, 3'b011);
    driveFrame(70, 1'b0);
    check("ovf_sticky", o_overflow, 1'b1);

    // Random cameras; each new start must also clear the sticky overflow.
    for (int f = 0; f < 8; f++) begin
      vbase = {$urandom, $urandom, $urandom};
      vr    = {$urandom, $urandom, $urandom};
      applyStimulus({$urandom, $urandom, $urandom}, vbase, vr, {$urandom, $urandom, $urandom});
      driveFrame($urandom_range(30, 100), $urandom_range(0, 1));
    end

    // Reset after the third handshake of a frame.
    p0 = pops;
    applyStimulus(mk(2, 3, 4), m1, ustep_u, ustep_v);
    cyc = 0;
    while (pops - p0 < 3 && cyc < 50) begin
      @(posedge clk); #1;
      ready = 1'b1;
      cyc++;
    end
    check("pre_reset_pops", pops - p0, 3);
    reset = 1'b1;
    exp_q.delete();
    done_pending = 1'b0;
    post_ovf = 1'b0;
    #1;
    check("mid_rst_valid", o_valid, 1'b0);
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_done", o_done, 1'b0);
    check("mid_rst_last", o_last, 1'b0);
    check("mid_rst_ray", {o_ray[0], o_ray[1]} == '0, 1'b1);
    check("mid_rst_pxpy", {o_px, o_py}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(mk(2, 3, 4), m1, ustep_u, ustep_v);
    check("restart_dir0", exp_q[0].dir, mk(-1, -1, -1));
    driveFrame(80, 1'b0);

    // Single-pixel frame on the 1x1 instance.
    s_eye  = {$urandom, $urandom, $urandom};
    s_base = {$urandom, $urandom, $urandom};
    s_du   = {$urandom, $urandom, $urandom};
    s_dv   = {$urandom, $urandom, $urandom};
    @(posedge clk); #1;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    @(negedge clk);
    check("one_valid", s_valid, 1'b1);
    check("one_last", s_last, 1'b1);
    check("one_dir", s_ray[1], s_base);
    check("one_origin", s_ray[0], s_eye);
    check("one_pxpy", {s_px, s_py}, 2'b00);
    check("one_ovf", s_overflow, 1'b0);
    @(negedge clk);
    check("one_done", s_done, 1'b1);
    check("one_idle", {s_valid, s_busy}, 2'b00);
    @(negedge clk);
    check("one_done_pulse", s_done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ray_gen.md
# ray_gen

Streaming camera-ray generator that produces the rays consumed by the ray–triangle intersection stage. On start, it latches a camera description and emits one Q16.16 ray per pixel in raster order, using a valid/ready handshake. Per-pixel directions are formed incrementally with adders only; there are no multipliers. Output ray format is origin (index 0) and direction (index 1), matching the intersection stage's ray input.

## Interface
- WIDTH, 320: pixels per row, ≥1
- HEIGHT, 240: rows per frame, ≥1
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- i_start  in  1  begin frame; sampled only in IDLE
- i_eye  in  [0:2][31:0] signed  ray origin, Q16.16
- i_base  in  [0:2][31:0] signed  direction of pixel (0,0)
- i_du  in  [0:2][31:0] signed  direction step per +x
- i_dv  in  [0:2][31:0] signed  direction step per +y
- o_ray  out  [0:1][0:2][31:0] signed  [0]=origin, [1]=direction
- o_valid  out  1  o_ray/o_px/o_py/o_last valid
- i_ready  in  1  downstream accepts when o_valid & i_ready
- o_px  out  $clog2(WIDTH+1)  pixel x
- o_py  out  $clog2(HEIGHT+1)  pixel y
- o_last  out  1  current ray is pixel (WIDTH-1, HEIGHT-1)
- o_busy  out  1  in RUN
- o_done  out  1  one-cycle pulse after last handshake
- o_overflow  out  1  sticky: any direction add overflowed this frame

## Operation
- States: IDLE, RUN.
- IDLE & i_start: latch i_eye, i_du, i_dv. Set dir = row_base = i_base, px = py = 0, clear o_overflow. Go to RUN.
- i_start while in RUN: ignored. Camera inputs are not re-sampled mid-frame.
- RUN: o_valid = 1. o_ray[0] = latched eye; o_ray[1] = dir.
- On handshake, when not at the last pixel:
  - px < WIDTH-1: dir ← dir + du, px++.
  - Otherwise: row_base ← row_base + dv, dir ← row_base + dv, px ← 0, py++.
- On handshake at the last pixel: go to IDLE, o_valid ← 0, o_done ← 1 for one cycle.
- Arithmetic: 32-bit two's-complement Q16.16. Sums wrap. Any component overflow in an add whose result is registered sets o_overflow, which stays set until the next accepted start.
- o_last = (px == WIDTH-1) & (py == HEIGHT-1).
- WIDTH = 1: every handshake takes the row-advance path.
- WIDTH = HEIGHT = 1: the first handshake ends the frame.

## Timing
- Reset values: state IDLE; o_valid, o_busy, o_done, o_last, o_overflow = 0; o_ray, o_px, o_py = 0. Internal registers are 0.
- Start latency: i_start in cycle N → o_valid = 1 with pixel (0,0) in cycle N+1.
- Throughput: one ray per cycle while i_ready is held high. A frame with no stalls takes WIDTH*HEIGHT cycles of valid.
- Backpressure: while o_valid & !i_ready, o_ray, o_px, o_py and o_last hold stable. o_valid never deasserts without a handshake, except on reset.
- o_done: asserted in the cycle after the last handshake. o_busy falls in that same cycle. A new i_start is accepted in that cycle.
- Reset mid-frame: o_valid drops immediately (asynchronous). The partial frame is discarded and no o_done is produced.

## Structure
- Package ray_pkg:
  - typedefs fip32_t (logic signed [31:0]), vec3_t ([0:2] fip32_t), ray_t ([0:1] vec3_t)
  - constant FIP_ONE = 32'sh0001_0000
  - enum for IDLE/RUN
- Sub-module ray_gen_vec3_add: three fip_32_adder instances with their overflow outputs ORed. Instantiate twice: dir+du and row_base+dv.
- Top level holds the FSM, counters and registers; expected size is about 150–250 lines.

## Test plan
- 2×2 frame, eye (0,0,0), base (-1,-1,-1)·FIP_ONE, du = (1,0,0)·FIP_ONE, dv = (0,1,0)·FIP_ONE, i_ready always high → directions in order (-1,-1,-1), (0,-1,-1), (-1,0,-1), (0,0,-1). o_last only on the 4th ray; o_done one cycle later.
- Same frame with i_ready toggling randomly → identical 4-ray sequence; outputs stable during every stall; exactly 4 handshakes.
- 1×1 frame → one ray equal to base; o_last = 1; o_done on the next cycle; returns to IDLE.
- base x = 32'sh7FFF_0000, du x = FIP_ONE, 3×1 frame → second ray x wraps to 32'sh8000_0000; o_overflow = 1 and stays set to frame end; cleared by the next start.
- i_start pulsed mid-frame with different camera values → ignored; sequence unchanged.
- Reset asserted after the 3rd handshake of a 4×4 frame → o_valid = 0 immediately, all outputs at reset values, no o_done. A new start reproduces pixel (0,0).
